// File: rtl/iomem_arbiter.sv
// Two-master round-robin arbiter for the iomem valid/ready bus.
// Grant is held per transaction; a watchdog forces error completions.
module iomem_arbiter #(
    parameter int          TIMEOUT   = 64,
    parameter logic [31:0] ERR_RDATA = 32'hDEAD_BEEF
) (
    input  logic        clk_i,
    input  logic        rst_n,
    input  logic        m0_valid,
    input  logic [3:0]  m0_wstrb,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    output logic        m0_ready,
    output logic [31:0] m0_rdata,
    input  logic        m1_valid,
    input  logic [3:0]  m1_wstrb,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    output logic        m1_ready,
    output logic [31:0] m1_rdata,
    output logic        s_valid,
    output logic [3:0]  s_wstrb,
    output logic [31:0] s_addr,
    output logic [31:0] s_wdata,
    input  logic        s_ready,
    input  logic [31:0] s_rdata,
    output logic        grant_o,
    output logic        busy_o,
    output logic        timeout_o
);

    localparam int WDW = $clog2(TIMEOUT + 1);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t           r_state, w_state_nx;
    logic             r_grant, w_grant_nx;
    logic             r_last_grant, w_last_grant_nx;
    logic [WDW-1:0]   r_wdog, w_wdog_nx;

    logic w_busy;
    logic w_done;
    logic w_tmo;
    logic w_fin;

    assign w_busy = (r_state == BUSY);
    assign w_done = w_busy && s_ready;
    // s_ready in the watchdog cycle wins over the forced completion
    assign w_tmo  = w_busy && !s_ready && (r_wdog == WDW'(TIMEOUT - 1));
    assign w_fin  = w_done || w_tmo;

    always_ff @(posedge clk_i) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_grant      <= 1'b0;
            r_last_grant <= 1'b1;
            r_wdog       <= '0;
        end else begin
            r_state      <= w_state_nx;
            r_grant      <= w_grant_nx;
            r_last_grant <= w_last_grant_nx;
            r_wdog       <= w_wdog_nx;
        end
    end

    always_comb begin
        w_state_nx      = r_state;
        w_grant_nx      = r_grant;
        w_last_grant_nx = r_last_grant;
        w_wdog_nx       = r_wdog;
        case (r_state)
            IDLE: begin
                if (m0_valid || m1_valid) begin
                    w_state_nx = BUSY;
                    w_wdog_nx  = '0;
                    if (m0_valid && m1_valid)
                        w_grant_nx = ~r_last_grant;
                    else
                        w_grant_nx = m1_valid;
                end
            end
            BUSY: begin
                if (w_fin) begin
                    w_state_nx      = IDLE;
                    w_last_grant_nx = r_grant;
                    w_wdog_nx       = '0;
                end else begin
                    w_wdog_nx = r_wdog + WDW'(1);
                end
            end
            default: w_state_nx = IDLE;
        endcase
    end

    assign s_valid  = w_busy;
    assign s_wstrb  = !w_busy ? 4'h0  : (r_grant ? m1_wstrb : m0_wstrb);
    assign s_addr   = !w_busy ? 32'h0 : (r_grant ? m1_addr  : m0_addr);
    assign s_wdata  = !w_busy ? 32'h0 : (r_grant ? m1_wdata : m0_wdata);

    assign m0_ready  = w_fin && !r_grant;
    assign m1_ready  = w_fin && r_grant;
    assign m0_rdata  = w_tmo ? ERR_RDATA : s_rdata;
    assign m1_rdata  = w_tmo ? ERR_RDATA : s_rdata;

    assign grant_o   = r_grant;
    assign busy_o    = w_busy;
    assign timeout_o = w_tmo;

endmodule

// File: tb/tb_iomem_arbiter.sv
// Directed bench for iomem_arbiter: arbitration, muxing,
// watchdog timeout and mid-transaction reset.
module tb_iomem_arbiter;

    logic        clk_i = 1'b0;
    logic        rst_n;
    logic        m0_valid, m1_valid;
    logic [3:0]  m0_wstrb, m1_wstrb;
    logic [31:0] m0_addr, m1_addr, m0_wdata, m1_wdata;
    logic        m0_ready, m1_ready;
    logic [31:0] m0_rdata, m1_rdata;
    logic        s_valid;
    logic [3:0]  s_wstrb;
    logic [31:0] s_addr, s_wdata;
    logic        s_ready;
    logic [31:0] s_rdata;
    logic        grant_o, busy_o, timeout_o;

    int n_vec = 0;
    int n_err = 0;

    iomem_arbiter #(.TIMEOUT(64), .ERR_RDATA(32'hDEAD_BEEF)) dut (
        .clk_i(clk_i), .rst_n(rst_n),
        .m0_valid(m0_valid), .m0_wstrb(m0_wstrb), .m0_addr(m0_addr),
        .m0_wdata(m0_wdata), .m0_ready(m0_ready), .m0_rdata(m0_rdata),
        .m1_valid(m1_valid), .m1_wstrb(m1_wstrb), .m1_addr(m1_addr),
        .m1_wdata(m1_wdata), .m1_ready(m1_ready), .m1_rdata(m1_rdata),
        .s_valid(s_valid), .s_wstrb(s_wstrb), .s_addr(s_addr),
        .s_wdata(s_wdata), .s_ready(s_ready), .s_rdata(s_rdata),
        .grant_o(grant_o), .busy_o(busy_o), .timeout_o(timeout_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    logic [31:0] a0, a1;
    logic        eg;

    initial begin
        rst_n = 1'b0;
        m0_valid = 0; m0_wstrb = 0; m0_addr = 0; m0_wdata = 0;
        m1_valid = 0; m1_wstrb = 0; m1_addr = 0; m1_wdata = 0;
        s_ready = 0; s_rdata = 0;
        tick(); tick();
        #1;
        chk("rst_svalid", {31'b0, s_valid}, 0);
        chk("rst_busy", {31'b0, busy_o}, 0);
        chk("rst_grant", {31'b0, grant_o}, 0);
        chk("rst_rdy", {30'b0, m0_ready, m1_ready}, 0);
        chk("rst_tmo", {31'b0, timeout_o}, 0);
        chk("rst_saddr", s_addr, 0);
        rst_n = 1'b1;
        tick();

        // single m0 read, s_ready 3 cycles after s_valid
        m0_valid = 1; m0_addr = 32'h4000_0010; m0_wstrb = 0;
        #1;
        chk("rd_idle_sv", {31'b0, s_valid}, 0);
        tick();
        chk("rd_sv", {31'b0, s_valid}, 1);
        chk("rd_saddr", s_addr, 32'h4000_0010);
        chk("rd_grant", {31'b0, grant_o}, 0);
        chk("rd_early_rdy", {31'b0, m0_ready}, 0);
        tick(); tick(); tick();
        s_ready = 1; s_rdata = 32'h1234_5678;
        #1;
        chk("rd_rdy", {31'b0, m0_ready}, 1);
        chk("rd_rdata", m0_rdata, 32'h1234_5678);
        chk("rd_m1rdy", {31'b0, m1_ready}, 0);
        chk("rd_tmo", {31'b0, timeout_o}, 0);
        tick();
        m0_valid = 0; s_ready = 0;
        #1;
        chk("rd_after_rdy", {31'b0, m0_ready}, 0);
        chk("rd_after_busy", {31'b0, busy_o}, 0);

        // contention from reset: strict alternation 0,1,0,1
        rst_n = 0; tick(); rst_n = 1; tick();
        a0 = 32'h4000_0020; a1 = 32'h4000_0030;
        m0_valid = 1; m0_addr = a0;
        m1_valid = 1; m1_addr = a1;
        for (int k = 0; k < 4; k++) begin
            eg = k[0];
            #1;
            chk("rr_idle_sv", {31'b0, s_valid}, 0);
            tick();
            chk("rr_grant", {31'b0, grant_o}, {31'b0, eg});
            chk("rr_saddr", s_addr, eg ? a1 : a0);
            s_ready = 1; s_rdata = 32'h100 + k;
            #1;
            chk("rr_rdy", {30'b0, m1_ready, m0_ready},
                eg ? 32'd2 : 32'd1);
            tick();
            s_ready = 0;
        end
        m0_valid = 0; m1_valid = 0;
        tick();

        // m1 partial write
        m1_valid = 1; m1_addr = 32'h4000_0100;
        m1_wstrb = 4'b0011; m1_wdata = 32'hAABB_CCDD;
        tick();
        chk("wr_grant", {31'b0, grant_o}, 1);
        chk("wr_saddr", s_addr, 32'h4000_0100);
        chk("wr_wstrb", {28'b0, s_wstrb}, 32'h3);
        chk("wr_wdata", s_wdata, 32'hAABB_CCDD);
        tick();
        chk("wr_wdata2", s_wdata, 32'hAABB_CCDD);
        s_ready = 1;
        #1;
        chk("wr_rdy", {30'b0, m1_ready, m0_ready}, 32'd2);
        tick();
        m1_valid = 0; m1_wstrb = 0; s_ready = 0;
        tick();

        // watchdog timeout at BUSY cycle 64
        m0_valid = 1; m0_addr = 32'h4000_0200;
        tick();
        repeat (62) tick();
        chk("to_63_tmo", {31'b0, timeout_o}, 0);
        chk("to_63_rdy", {31'b0, m0_ready}, 0);
        tick();
        chk("to_tmo", {31'b0, timeout_o}, 1);
        chk("to_rdy", {31'b0, m0_ready}, 1);
        chk("to_rdata", m0_rdata, 32'hDEAD_BEEF);
        chk("to_sv", {31'b0, s_valid}, 1);
        tick();
        m0_valid = 0;
        #1;
        chk("to_busy", {31'b0, busy_o}, 0);
        chk("to_tmo_off", {31'b0, timeout_o}, 0);
        s_ready = 1;
        #1;
        chk("late_rdy", {30'b0, m1_ready, m0_ready}, 0);
        tick();
        s_ready = 0;
        tick();

        // s_ready in the timeout cycle wins
        m0_valid = 1;
        tick();
        repeat (63) tick();
        s_ready = 1; s_rdata = 32'h5555_AAAA;
        #1;
        chk("tie_rdy", {31'b0, m0_ready}, 1);
        chk("tie_rdata", m0_rdata, 32'h5555_AAAA);
        chk("tie_tmo", {31'b0, timeout_o}, 0);
        tick();
        m0_valid = 0; s_ready = 0;
        tick();

        // reset during m1 transaction
        m1_valid = 1; m1_addr = 32'h4000_0300;
        tick();
        chk("mr_grant", {31'b0, grant_o}, 1);
        chk("mr_busy", {31'b0, busy_o}, 1);
        rst_n = 0;
        #1;
        chk("mr_no_rdy0", {31'b0, m1_ready}, 0);
        tick();
        chk("mr_busy_off", {31'b0, busy_o}, 0);
        chk("mr_sv_off", {31'b0, s_valid}, 0);
        chk("mr_no_rdy", {31'b0, m1_ready}, 0);
        rst_n = 1;
        m0_valid = 1; m0_addr = 32'h4000_0400;
        tick();
        chk("mr_tie_grant", {31'b0, grant_o}, 0);
        chk("mr_tie_saddr", s_addr, 32'h4000_0400);
        s_ready = 1;
        #1;
        chk("mr_tie_rdy", {30'b0, m1_ready, m0_ready}, 32'd1);
        tick();
        m0_valid = 0; m1_valid = 0; s_ready = 0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
